mecobo_cmd_sequencer: RTL and testbench

Multi-cycle command sequencer between the shared instruction/data RAM (one port of the dual-port block RAM written by the EBI side) and the pin controllers. It polls a fixed instruction word, decodes it, fetches the attached data words, and delivers them one by one to the addressed pin controller over a valid/ready configuration bus. It is the only master on its RAM port.

---
 rtl/mecobo_cmd_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_mecobo_cmd_sequencer.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mecobo_cmd_sequencer.sv
// mecobo_cmd_sequencer
// Polls the instruction word in shared RAM, decodes it, fetches the payload
// words and hands them one at a time to the addressed pin controller over a
// valid/ready configuration bus. This block is the only master on its RAM port.
//
// Build option: define CMD_ACK_WRITEBACK_EN to have ACK overwrite the
// instruction word with 0x0000. Without it, the last executed word is
// remembered and a re-fetched identical word is treated as NOP.
module mecobo_cmd_sequencer #(
    parameter logic [20:0] INSTR_ADDR = 21'h000002
) (
    input  logic        clk,
    input  logic        reset,
    output logic [20:0] ram_addr,
    input  logic [15:0] ram_data_in,
    output logic [15:0] ram_data_out,
    output logic        ram_wr,
    output logic        ram_en,
    output logic [3:0]  cfg_pin,
    output logic [3:0]  cfg_idx,
    output logic [15:0] cfg_data,
    output logic        cfg_clear,
    output logic        cfg_valid,
    input  logic        cfg_ready,
    output logic        busy,
    output logic        err
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_DECODE    = 3'd2;
    localparam logic [2:0] ST_DATA_RD   = 3'd3;
    localparam logic [2:0] ST_DATA_WAIT = 3'd4;
    localparam logic [2:0] ST_CFG       = 3'd5;
    localparam logic [2:0] ST_ACK       = 3'd6;

    localparam logic [3:0] OP_NOP       = 4'd0;
    localparam logic [3:0] OP_PROGRAM   = 4'd1;
    localparam logic [3:0] OP_RESET_PIN = 4'd2;

    logic [2:0]  state_q;
    logic [2:0]  state_d;

    logic [3:0]  op_q;
    logic [3:0]  cnt_q;
    logic [3:0]  ctr_q;

    logic [3:0]  cfg_pin_q;
    logic [3:0]  cfg_idx_q;
    logic [15:0] cfg_data_q;
    logic        cfg_clear_q;
    logic        err_q;

    logic [3:0]  word_op;
    logic [3:0]  word_pin;
    logic [3:0]  word_cnt;
    logic        word_is_nop;
    logic        word_legal;
    logic        beat_done;
    logic        more_beats;
    logic [20:0] data_addr;

    assign word_op  = ram_data_in[15:12];
    assign word_pin = ram_data_in[11:8];
    assign word_cnt = ram_data_in[3:0];

`ifdef CMD_ACK_WRITEBACK_EN
    // The reserved field is never looked at when the word is consumed by ACK.
    logic unused_rsvd;
    assign unused_rsvd = ^ram_data_in[7:4];
    assign word_is_nop = (word_op == OP_NOP);
`else
    // Remembered copy of the last executed word; a re-fetched identical word
    // (including reserved bits) is treated as already done.
    logic [15:0] last_word_q;
    assign word_is_nop = (word_op == OP_NOP) || (ram_data_in == last_word_q);
`endif

    assign word_legal = (word_op == OP_PROGRAM) || (word_op == OP_RESET_PIN);
    assign beat_done  = (state_q == ST_CFG) && cfg_ready;
    assign more_beats = (op_q == OP_PROGRAM) && (ctr_q < cnt_q);
    assign data_addr  = INSTR_ADDR + 21'd1 + {17'd0, ctr_q};

    // Next-state selection for the command sequencing FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      state_d = ST_FETCH;
            ST_FETCH:     state_d = ST_DECODE;
            ST_DECODE: begin
                if (word_is_nop) begin
                    state_d = ST_IDLE;
                end else if (word_op == OP_PROGRAM) begin
                    state_d = ST_DATA_RD;
                end else if (word_op == OP_RESET_PIN) begin
                    state_d = ST_CFG;
                end else begin
                    state_d = ST_ACK;
                end
            end
            ST_DATA_RD:   state_d = ST_DATA_WAIT;
            ST_DATA_WAIT: state_d = ST_CFG;
            ST_CFG: begin
                if (cfg_ready) begin
                    state_d = more_beats ? ST_DATA_RD : ST_ACK;
                end
            end
            ST_ACK:       state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // State register; reset aborts any command in flight immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched command fields, beat counter and the held configuration beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q        <= '0;
            cnt_q       <= '0;
            ctr_q       <= '0;
            cfg_pin_q   <= '0;
            cfg_idx_q   <= '0;
            cfg_data_q  <= '0;
            cfg_clear_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_DECODE: begin
                    if (!word_is_nop) begin
                        op_q        <= word_op;
                        cnt_q       <= word_cnt;
                        ctr_q       <= '0;
                        cfg_pin_q   <= word_pin;
                        cfg_clear_q <= (word_op == OP_RESET_PIN);
                        err_q       <= !word_legal;
                        if (word_op == OP_RESET_PIN) begin
                            cfg_idx_q  <= '0;
                            cfg_data_q <= '0;
                        end
                    end
                end
                ST_DATA_WAIT: begin
                    cfg_data_q <= ram_data_in;
                    cfg_idx_q  <= ctr_q;
                end
                ST_CFG: begin
                    if (beat_done && more_beats) begin
                        ctr_q <= ctr_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef CMD_ACK_WRITEBACK_EN
    // Record every executed word at decode so the next poll skips it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_word_q <= '0;
        end else if ((state_q == ST_DECODE) && !word_is_nop) begin
            last_word_q <= ram_data_in;
        end
    end
`endif

    // RAM port drive: instruction fetch, payload reads and optional ACK write.
    always_comb begin
        ram_en   = 1'b0;
        ram_wr   = 1'b0;
        ram_addr = INSTR_ADDR;
        case (state_q)
            ST_FETCH: begin
                ram_en = 1'b1;
            end
            ST_DATA_RD: begin
                ram_en   = 1'b1;
                ram_addr = data_addr;
            end
`ifdef CMD_ACK_WRITEBACK_EN
            ST_ACK: begin
                ram_en = 1'b1;
                ram_wr = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // The only write ever issued clears the instruction word, so write data is always zero.
    assign ram_data_out = '0;

    assign cfg_pin   = cfg_pin_q;
    assign cfg_idx   = cfg_idx_q;
    assign cfg_data  = cfg_data_q;
    assign cfg_clear = cfg_clear_q;
    assign cfg_valid = (state_q == ST_CFG);
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_FETCH);
    assign err       = err_q;

endmodule

// File: tb/tb_mecobo_cmd_sequencer.sv
// Self-checking bench for mecobo_cmd_sequencer: a RAM model feeds the DUT,
// expected configuration beats are queued and compared as they are accepted.
module tb_mecobo_cmd_sequencer;

    localparam logic [20:0] IA = 21'h000002;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [20:0] ram_addr;
    logic [15:0] ram_data_in;
    logic [15:0] ram_data_out;
    logic        ram_wr;
    logic        ram_en;
    logic [3:0]  cfg_pin;
    logic [3:0]  cfg_idx;
    logic [15:0] cfg_data;
    logic        cfg_clear;
    logic        cfg_valid;
    logic        cfg_ready = 1'b0;
    logic        busy;
    logic        err;

    int vectors = 0;
    int miscompares = 0;
    int beats_seen = 0;

    typedef struct packed {
        logic [3:0]  pin;
        logic [3:0]  idx;
        logic [15:0] data;
        logic        clr;
    } beat_t;

    beat_t exp_q[$];

    always #5 clk = ~clk;

    mecobo_cmd_sequencer #(.INSTR_ADDR(IA)) dut (
        .clk          (clk),
        .reset        (reset),
        .ram_addr     (ram_addr),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out),
        .ram_wr       (ram_wr),
        .ram_en       (ram_en),
        .cfg_pin      (cfg_pin),
        .cfg_idx      (cfg_idx),
        .cfg_data     (cfg_data),
        .cfg_clear    (cfg_clear),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .busy         (busy),
        .err          (err)
    );

    // RAM model: one-cycle read latency, host (EBI side) writes via host_we.
    logic [15:0] mem [0:31] = '{default: 16'h0000};
    logic [15:0] rd_q = '0;
    logic        host_we = 1'b0;
    logic [4:0]  host_addr = '0;
    logic [15:0] host_data = '0;
    int          wr_cnt = 0;
    logic [20:0] last_wr_addr = '0;
    logic [15:0] last_wr_data = '0;

    assign ram_data_in = rd_q;

    always @(posedge clk) begin
        if (host_we) mem[host_addr] <= host_data;
        if (ram_en && ram_wr) begin
            mem[ram_addr[4:0]] <= ram_data_out;
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= ram_addr;
            last_wr_data <= ram_data_out;
        end
        if (ram_en && !ram_wr) rd_q <= mem[ram_addr[4:0]];
    end

    // Beat monitor: scoreboard pop on acceptance, hold check while stalled.
    initial begin
        logic        pv;
        logic        pr;
        logic [24:0] pbeat;
        beat_t       e;
        pv = 1'b0;
        pr = 1'b0;
        pbeat = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pv = 1'b0;
                continue;
            end
            if (ram_en && (ram_addr > 21'd31)) begin
                vectors++;
                miscompares++;
                $display("FAIL ram_range: addr=%h outside model", ram_addr);
            end
            if (pv && !pr) begin
                vectors++;
                if (!cfg_valid || ({cfg_pin, cfg_idx, cfg_data, cfg_clear} !== pbeat)) begin
                    miscompares++;
                    $display("FAIL cfg_hold: valid=%b beat=%h required valid=1 beat=%h",
                             cfg_valid, {cfg_pin, cfg_idx, cfg_data, cfg_clear}, pbeat);
                end
            end
            if (cfg_valid && cfg_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL beat_unexpected: pin=%h idx=%h data=%h clr=%b",
                             cfg_pin, cfg_idx, cfg_data, cfg_clear);
                end else begin
                    e = exp_q.pop_front();
                    if ({cfg_pin, cfg_idx, cfg_data, cfg_clear} !== e) begin
                        miscompares++;
                        $display("FAIL beat: got pin=%h idx=%h data=%h clr=%b required pin=%h idx=%h data=%h clr=%b",
                                 cfg_pin, cfg_idx, cfg_data, cfg_clear, e.pin, e.idx, e.data, e.clr);
                    end
                end
                beats_seen++;
            end
            pv = cfg_valid;
            pr = cfg_ready;
            pbeat = {cfg_pin, cfg_idx, cfg_data, cfg_clear};
        end
    end

    task automatic host_write(input logic [4:0] a, input logic [15:0] d);
        @(negedge clk);
        host_addr = a;
        host_data = d;
        host_we   = 1'b1;
        @(negedge clk);
        host_we   = 1'b0;
    endtask

    task automatic push_beat(input logic [3:0] p, input logic [3:0] i,
                             input logic [15:0] d, input logic c);
        beat_t b;
        b.pin = p; b.idx = i; b.data = d; b.clr = c;
        exp_q.push_back(b);
    endtask

    // Waits for the next busy run; reports cycles to first cfg_valid, run length, err cycles.
    task automatic run_cmd(output int lat, output int len, output int errs, output bit tmo);
        int n;
        lat = -1; len = 0; errs = 0; tmo = 1'b0; n = 0;
        @(negedge clk);
        while (!busy && n < 200) begin @(negedge clk); n++; end
        if (!busy) begin tmo = 1'b1; return; end
        n = 0;
        while (busy && n < 500) begin
            if (cfg_valid && lat < 0) lat = len;
            if (err) errs++;
            len++;
            @(negedge clk);
            n++;
        end
        if (busy) tmo = 1'b1;
    endtask

    task automatic check_run(input string name, input int lat, input int len, input int errs,
                             input bit tmo, input int lat_x, input int len_x, input int errs_x);
        vectors++;
        if (tmo || lat != lat_x || len != len_x || errs != errs_x) begin
            miscompares++;
            $display("FAIL %s: tmo=%0b lat=%0d len=%0d err=%0d required tmo=0 lat=%0d len=%0d err=%0d",
                     name, tmo, lat, len, errs, lat_x, len_x, errs_x);
        end
    endtask

    task automatic test_reset();
        logic [66:0] exp_v;
        exp_v = {IA, 46'd0};
        repeat (3) @(negedge clk);
        vectors++;
        if ({ram_addr, ram_en, ram_wr, ram_data_out, cfg_pin, cfg_idx, cfg_data,
             cfg_clear, cfg_valid, busy, err} !== exp_v) begin
            miscompares++;
            $display("FAIL reset_state: got %h required %h",
                     {ram_addr, ram_en, ram_wr, ram_data_out, cfg_pin, cfg_idx, cfg_data,
                      cfg_clear, cfg_valid, busy, err}, exp_v);
        end
    endtask

    task automatic test_nop();
        int nb, ni, no, nv, w0;
        host_write(5'd2, 16'h0000);
        cfg_ready = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        w0 = wr_cnt;
        nb = 0; ni = 0; no = 0; nv = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (cfg_valid) nv++;
            if (ram_en && !ram_wr) begin
                if (ram_addr == IA) ni++; else no++;
            end
        end
        vectors++;
        if (nb != 10 || ni != 10 || no != 0 || nv != 0 || wr_cnt != w0) begin
            miscompares++;
            $display("FAIL nop_poll: busy=%0d fetch=%0d other_rd=%0d valid=%0d wr=%0d required 10 10 0 0 0",
                     nb, ni, no, nv, wr_cnt - w0);
        end
    endtask

    task automatic test_program();
        int lat, len, errs, w0, nb, nv;
        bit tmo;
        host_write(5'd3, 16'hA001);
        host_write(5'd4, 16'hA002);
        host_write(5'd5, 16'hA003);
        cfg_ready = 1'b1;
        push_beat(4'd3, 4'd0, 16'hA001, 1'b0);
        push_beat(4'd3, 4'd1, 16'hA002, 1'b0);
        push_beat(4'd3, 4'd2, 16'hA003, 1'b0);
        w0 = wr_cnt;
        host_write(5'd2, 16'h1302);
        run_cmd(lat, len, errs, tmo);
        check_run("program_run", lat, len, errs, tmo, 3, 11, 0);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL program_beats: %0d beats outstanding required 0", exp_q.size());
        end
`ifdef CMD_ACK_WRITEBACK_EN
        vectors++;
        if (wr_cnt != w0 + 1 || last_wr_addr !== IA || last_wr_data !== 16'h0000 || mem[2] !== 16'h0000) begin
            miscompares++;
            $display("FAIL program_ack: writes=%0d addr=%h data=%h word=%h required 1 %h 0000 0000",
                     wr_cnt - w0, last_wr_addr, last_wr_data, mem[2], IA);
        end
`else
        vectors++;
        if (wr_cnt != w0 || mem[2] !== 16'h1302) begin
            miscompares++;
            $display("FAIL program_ack: writes=%0d word=%h required 0 1302", wr_cnt - w0, mem[2]);
        end
`endif
        nb = 0; nv = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (cfg_valid) nv++;
        end
        vectors++;
        if (nb != 10 || nv != 0) begin
            miscompares++;
            $display("FAIL program_no_repeat: busy=%0d valid=%0d required 10 0", nb, nv);
        end
    endtask

    task automatic test_backpressure();
        int lat, len, errs, n;
        bit tmo;
        host_write(5'd3, 16'hB001);
        host_write(5'd4, 16'hB002);
        host_write(5'd5, 16'hB003);
        cfg_ready = 1'b0;
        push_beat(4'd3, 4'd0, 16'hB001, 1'b0);
        push_beat(4'd3, 4'd1, 16'hB002, 1'b0);
        push_beat(4'd3, 4'd2, 16'hB003, 1'b0);
        host_write(5'd2, 16'h1312);
        fork
            begin
                run_cmd(lat, len, errs, tmo);
            end
            begin
                for (int b = 0; b < 3; b++) begin
                    n = 0;
                    @(negedge clk);
                    while (!cfg_valid && n < 100) begin @(negedge clk); n++; end
                    if (!cfg_valid) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL stall_wait: beat %0d valid=0 required 1", b);
                        break;
                    end
                    repeat (4) @(negedge clk);
                    @(posedge clk); #1 cfg_ready = 1'b1;
                    @(posedge clk); #1 cfg_ready = 1'b0;
                end
            end
        join
        check_run("stall_run", lat, len, errs, tmo, 3, 26, 0);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL stall_beats: %0d beats outstanding required 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset_pin();
        int lat, len, errs;
        bit tmo;
        cfg_ready = 1'b1;
        push_beat(4'd5, 4'd0, 16'h0000, 1'b1);
        host_write(5'd2, 16'h2500);
        run_cmd(lat, len, errs, tmo);
        check_run("reset_pin_run", lat, len, errs, tmo, 1, 3, 0);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL reset_pin_beat: %0d beats outstanding required 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_illegal();
        int lat, len, errs, ne, w0;
        bit tmo;
        cfg_ready = 1'b1;
        w0 = wr_cnt;
        host_write(5'd2, 16'h7000);
        run_cmd(lat, len, errs, tmo);
        check_run("illegal_run", lat, len, errs, tmo, -1, 2, 1);
        ne = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (err) ne++;
        end
        vectors++;
        if (ne != 0) begin
            miscompares++;
            $display("FAIL illegal_err_once: extra err cycles=%0d required 0", ne);
        end
`ifdef CMD_ACK_WRITEBACK_EN
        vectors++;
        if (wr_cnt != w0 + 1 || mem[2] !== 16'h0000) begin
            miscompares++;
            $display("FAIL illegal_ack: writes=%0d word=%h required 1 0000", wr_cnt - w0, mem[2]);
        end
`else
        vectors++;
        if (wr_cnt != w0) begin
            miscompares++;
            $display("FAIL illegal_ack: writes=%0d required 0", wr_cnt - w0);
        end
`endif
    endtask

    task automatic test_abort();
        int lat, len, errs, n, b0, w0;
        bit tmo;
        logic [66:0] exp_v;
        exp_v = {IA, 46'd0};
        for (int i = 0; i < 16; i++) host_write(5'(3 + i), 16'hC000 + 16'(i));
        cfg_ready = 1'b1;
        for (int i = 0; i < 16; i++) push_beat(4'd0, 4'(i), 16'hC000 + 16'(i), 1'b0);
        b0 = beats_seen;
        w0 = wr_cnt;
        host_write(5'd2, 16'h100F);
        n = 0;
        while (beats_seen != b0 + 1 && n < 200) begin @(negedge clk); n++; end
        @(posedge clk); #1 cfg_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!cfg_valid && n < 50) begin @(negedge clk); n++; end
        vectors++;
        if (!cfg_valid || cfg_idx !== 4'd1 || cfg_data !== 16'hC001) begin
            miscompares++;
            $display("FAIL abort_second_beat: valid=%b idx=%h data=%h required 1 1 c001",
                     cfg_valid, cfg_idx, cfg_data);
        end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({ram_addr, ram_en, ram_wr, ram_data_out, cfg_pin, cfg_idx, cfg_data,
             cfg_clear, cfg_valid, busy, err} !== exp_v) begin
            miscompares++;
            $display("FAIL abort_reset_state: got %h required %h",
                     {ram_addr, ram_en, ram_wr, ram_data_out, cfg_pin, cfg_idx, cfg_data,
                      cfg_clear, cfg_valid, busy, err}, exp_v);
        end
        exp_q.delete();
        for (int i = 0; i < 16; i++) push_beat(4'd0, 4'(i), 16'hC000 + 16'(i), 1'b0);
        repeat (2) @(negedge clk);
        cfg_ready = 1'b1;
        reset = 1'b1;
        run_cmd(lat, len, errs, tmo);
        check_run("abort_restart_run", lat, len, errs, tmo, 3, 50, 0);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL abort_restart_beats: %0d beats outstanding required 0", exp_q.size());
        end
`ifdef CMD_ACK_WRITEBACK_EN
        vectors++;
        if (wr_cnt != w0 + 1) begin
            miscompares++;
            $display("FAIL abort_ack: writes=%0d required 1", wr_cnt - w0);
        end
`else
        vectors++;
        if (wr_cnt != w0) begin
            miscompares++;
            $display("FAIL abort_ack: writes=%0d required 0", wr_cnt - w0);
        end
`endif
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_nop();
        test_program();
        test_backpressure();
        test_reset_pin();
        test_illegal();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
